// File: rtl/gaussian_filter_pkg.sv
// rtl/gaussian_filter_pkg.sv - shared types, kernel constants and 3x3 Gaussian helper
package gaussian_filter_pkg;

    localparam int PIXEL_BIT_WIDTH = 16;
    localparam int KERNEL_SHIFT    = 4;
    localparam int ACC_WIDTH       = PIXEL_BIT_WIDTH + KERNEL_SHIFT;

    // Kernel [1 2 1; 2 4 2; 1 2 1] expressed as left-shift amounts
    localparam int W_CORNER_SHIFT = 0;
    localparam int W_EDGE_SHIFT   = 1;
    localparam int W_CENTRE_SHIFT = 2;

    typedef logic signed [PIXEL_BIT_WIDTH-1:0] pixel_t;
    typedef logic signed [ACC_WIDTH-1:0]       acc_t;
    typedef pixel_t                            window_t [3][3];

    // Weight of kernel tap (r,c) as a shift amount
    function automatic int kernel_shift(input int r, input int c);
        int edges;
        edges = ((r == 1) ? 1 : 0) + ((c == 1) ? 1 : 0);
        if (edges == 2)
            return W_CENTRE_SHIFT;
        else if (edges == 1)
            return W_EDGE_SHIFT;
        else
            return W_CORNER_SHIFT;
    endfunction

    // Weighted sum of the window, divided by 16 with floor (arithmetic shift).
    // The worst-case sum is 16 * full-scale, which fits ACC_WIDTH exactly.
    function automatic pixel_t gauss3x3(input window_t w);
        acc_t sum;
        acc_t shifted;
        sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum = sum + (acc_t'(w[r][c]) <<< kernel_shift(r, c));
            end
        end
        shifted = sum >>> KERNEL_SHIFT;
        return shifted[PIXEL_BIT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/gaussian_filter_if.sv
// rtl/gaussian_filter_if.sv - pixel-in / pixel-out valid-ready handshake bundle
interface gaussian_filter_if;
    import gaussian_filter_pkg::*;

    pixel_t pixel_in;
    logic   in_valid;
    logic   in_ready;
    pixel_t pixel_out;
    logic   out_valid;
    logic   out_ready;

    // The filter is the slave of this bundle: it sinks pixel_in and sources pixel_out
    modport slave (
        input  pixel_in, in_valid, out_ready,
        output in_ready, pixel_out, out_valid
    );

    // Producer/consumer side surrounding the filter
    modport master (
        output pixel_in, in_valid, out_ready,
        input  in_ready, pixel_out, out_valid
    );

endinterface

// File: rtl/gaussian_filter_line_buffer.sv
// rtl/gaussian_filter_line_buffer.sv - DEPTH-entry delay line advanced by an enable strobe
module gaussian_filter_line_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;

    // The slot about to be overwritten holds the sample written DEPTH strobes ago
    assign data_o = mem_q[ptr_q];

    // Circular pointer advances one slot per strobe
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage write; contents need no reset since they are refilled before use
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/gaussian_filter.sv
// rtl/gaussian_filter.sv - 3x3 Gaussian blur, valid-mode output, 1-cycle latency
module gaussian_filter
    import gaussian_filter_pkg::*;
#(
    parameter int ROWS = 48,
    parameter int COLS = 48
) (
    input  logic              clk,
    input  logic              reset,
    gaussian_filter_if.slave  bus
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    window_t       win_q, win_d;
    pixel_t        pixel_out_q, pixel_out_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_w;
    logic          accept;
    logic          complete;
    pixel_t        lb1_out;
    pixel_t        lb2_out;

    // Accept whenever the output slot is empty or being drained this cycle
    assign in_ready_w = ~out_valid_q | bus.out_ready;
    assign accept     = bus.in_valid & in_ready_w;
    // Gating on col>=2 keeps every emitted window inside a single row
    assign complete   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign bus.in_ready  = in_ready_w;
    assign bus.pixel_out = pixel_out_q;
    assign bus.out_valid = out_valid_q;

    // Previous row, then the row before it
    gaussian_filter_line_buffer #(.WIDTH(PIXEL_BIT_WIDTH), .DEPTH(COLS)) u_lb1 (
        .clk    (clk),
        .reset  (reset),
        .en_i   (accept),
        .data_i (bus.pixel_in),
        .data_o (lb1_out)
    );

    gaussian_filter_line_buffer #(.WIDTH(PIXEL_BIT_WIDTH), .DEPTH(COLS)) u_lb2 (
        .clk    (clk),
        .reset  (reset),
        .en_i   (accept),
        .data_i (lb1_out),
        .data_o (lb2_out)
    );

    // Raster position of the next pixel to be accepted
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == CW'(COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window shifts left one column per accept; new column is {row-2, row-1, row}
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_out;
            win_d[1][2] = lb1_out;
            win_d[2][2] = bus.pixel_in;
        end
    end

    // Output slot: reload on a completing accept, otherwise drain on out_ready
    always_comb begin
        out_valid_d = out_valid_q;
        pixel_out_d = pixel_out_q;
        if (complete) begin
            out_valid_d = 1'b1;
            pixel_out_d = gauss3x3(win_d);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Counters and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            pixel_out_q <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            pixel_out_q <= pixel_out_d;
        end
    end

    // Window registers; contents before the first full window are irrelevant
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

endmodule

// File: tb/tb_gaussian_filter.sv
// tb/tb_gaussian_filter.sv - scoreboard bench for gaussian_filter
module tb_gaussian_filter;
    import gaussian_filter_pkg::*;

    localparam int ROWS = 48;
    localparam int COLS = 48;
    localparam int NOUT = (ROWS - 2) * (COLS - 2);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gaussian_filter_if gif ();

    gaussian_filter #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (gif.slave)
    );

    int checks = 0;
    int errors = 0;
    int exp_q [$];
    int img [ROWS][COLS];
    int out_cnt;
    int first_out;
    int last_out;
    int drv_cycles;
    int bp_valid_cnt;
    bit mon_en;
    bit bp_hold;
    bit rdy_full;
    bit vld_full;
    bit stall_pend;
    int held;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference blur for the window whose bottom-right pixel is (r,c)
    function automatic int model_at(input int r, input int c);
        int s;
        int w;
        s = 0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                w = ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
                s += w * img[r-2+dr][c-2+dc];
            end
        end
        return s >>> 4;
    endfunction

    // mode 0: constant val, 1: ramp r*COLS+c, 2: impulse val at (5,5)
    task automatic fill(input int mode, input int val);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                case (mode)
                    0:       img[r][c] = val;
                    1:       img[r][c] = r * COLS + c;
                    default: img[r][c] = (r == 5 && c == 5) ? val : 0;
                endcase
            end
        end
    endtask

    // Downstream ready generator
    initial begin
        gif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold)
                gif.out_ready = 1'b0;
            else if (rdy_full)
                gif.out_ready = 1'b1;
            else
                gif.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor and scoreboard
    always @(negedge clk) begin
        if (reset) begin
            stall_pend = 1'b0;
        end else if (mon_en) begin
            if (gif.out_valid) begin
                if (stall_pend)
                    check("stable", int'($signed(gif.pixel_out)), held);
                if (gif.out_ready) begin
                    stall_pend = 1'b0;
                    check("q_nonempty", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0)
                        check("pixel", int'($signed(gif.pixel_out)), exp_q.pop_front());
                    if (out_cnt == 0)
                        first_out = int'($signed(gif.pixel_out));
                    last_out = int'($signed(gif.pixel_out));
                    out_cnt++;
                end else begin
                    stall_pend = 1'b1;
                    held = int'($signed(gif.pixel_out));
                end
            end else if (stall_pend) begin
                check("valid_held", int'(gif.out_valid), 1);
                stall_pend = 1'b0;
            end
            if (bp_hold && gif.out_valid) begin
                bp_valid_cnt++;
                check("bp_in_ready", int'(gif.in_ready), 0);
            end
        end
    end

    // Drive rows [0,nrows) of img; expected results queued on each completing accept
    task automatic send_rows(input int nrows);
        bit acc;
        int tries;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < COLS; c++) begin
                acc = 1'b0;
                tries = 0;
                gif.pixel_in = pixel_t'(img[r][c]);
                while (!acc) begin
                    gif.in_valid = vld_full || ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    acc = gif.in_valid && gif.in_ready;
                    if (acc && r >= 2 && c >= 2)
                        exp_q.push_back(model_at(r, c));
                    @(posedge clk);
                    #1;
                    drv_cycles++;
                    tries++;
                    if (!acc && tries > 1000) begin
                        check("accept_timeout", int'(acc), 1);
                        gif.in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        gif.in_valid = 1'b0;
    endtask

    task automatic drain_and_count(input string tag);
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !gif.out_valid)
                break;
            @(posedge clk);
            #1;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_count"}, out_cnt, NOUT);
    endtask

    task automatic run_frame(input string tag, input int mode, input int val);
        fill(mode, val);
        out_cnt = 0;
        drv_cycles = 0;
        send_rows(ROWS);
        drain_and_count(tag);
    endtask

    initial begin
        reset = 1'b1;
        gif.in_valid = 1'b0;
        gif.pixel_in = '0;
        mon_en = 1'b0;
        bp_hold = 1'b0;
        rdy_full = 1'b0;
        vld_full = 1'b0;
        stall_pend = 1'b0;
        bp_valid_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(gif.out_valid), 0);
        check("rst_pixel_out", int'(gif.pixel_out), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(gif.in_ready), 1);
        mon_en = 1'b1;

        run_frame("const100", 0, 100);
        run_frame("ramp", 1, 0);
        check("ramp_first", first_out, 49);
        check("ramp_last", last_out, 2254);
        run_frame("imp16", 2, 16);
        run_frame("imp_p1", 2, 1);
        run_frame("imp_m1", 2, -1);
        run_frame("const_m3", 0, -3);

        // Full-throughput frame with a 10-cycle downstream stall in the middle
        vld_full = 1'b1;
        rdy_full = 1'b1;
        fill(1, 0);
        out_cnt = 0;
        drv_cycles = 0;
        bp_valid_cnt = 0;
        fork
            send_rows(ROWS);
            begin
                repeat (1000) @(posedge clk);
                bp_hold = 1'b1;
                repeat (10) @(posedge clk);
                bp_hold = 1'b0;
            end
        join
        drain_and_count("bp");
        check("bp_stall_cycles", bp_valid_cnt, 10);
        check("full_cycles", drv_cycles, ROWS * COLS + 10);
        check("bp_last", last_out, 2254);
        vld_full = 1'b0;
        rdy_full = 1'b0;

        // Reset mid-frame, then a clean frame must start from (0,0)
        fill(1, 0);
        send_rows(20);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(gif.out_valid), 0);
        check("midrst_pixel_out", int'(gif.pixel_out), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_in_ready", int'(gif.in_ready), 1);
        run_frame("after_rst", 1, 0);
        check("after_rst_first", first_out, 49);
        check("after_rst_last", last_out, 2254);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
